// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle signed divider, one restoring step per clock;
//               flags divide-by-zero and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        SIGN   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_most_neg  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_width_cnt = CNT_W'(WIDTH);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dbz;
    logic             r_ovf;

    logic [WIDTH-1:0] w_abs_x;
    logic [WIDTH-1:0] w_abs_y;
    logic [WIDTH:0]   w_shift;
    logic             w_fit;
    logic [WIDTH-1:0] w_rem_next;

    // Magnitudes are unsigned, so |most-negative| = 2^(WIDTH-1) is exact.
    assign w_abs_x = x[WIDTH-1] ? (~x + 1'b1) : x;
    assign w_abs_y = y[WIDTH-1] ? (~y + 1'b1) : y;

    // The shifted partial remainder needs one extra bit before the compare;
    // after a successful subtract the true value always fits in WIDTH bits.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_fit      = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_fit ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            result      <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy     <= 1'b1;
                        r_sign_q <= x[WIDTH-1] ^ y[WIDTH-1];
                        r_sign_r <= x[WIDTH-1];
                        r_ovf    <= (x == c_most_neg) && (y == {WIDTH{1'b1}});
                        r_rem    <= '0;
                        if (y == '0) begin
                            // Keep the raw dividend; it is returned as the remainder.
                            r_dbz   <= 1'b1;
                            r_quo   <= x;
                            r_dvs   <= '0;
                            r_cnt   <= '0;
                            r_state <= SIGN;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_quo   <= w_abs_x;
                            r_dvs   <= w_abs_y;
                            r_cnt   <= c_width_cnt;
                            r_state <= DIVIDE;
                        end
                    end
                end

                DIVIDE: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], w_fit};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= SIGN;
                    end
                end

                SIGN: begin
                    if (r_dbz) begin
                        result      <= '0;
                        remainder   <= r_quo;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b1;
                    end else begin
                        // The overflow case wraps naturally to the most-negative value.
                        result      <= r_sign_q ? (~r_quo + 1'b1) : r_quo;
                        remainder   <= r_sign_r ? (~r_rem + 1'b1) : r_rem;
                        div_by_zero <= 1'b0;
                        overflow    <= r_ovf;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             overflow;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    int errors;
    int checks;

    seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .x           (x),
        .y           (y),
        .result      (result),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; sampled #1 after the accepting edge.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        x     = a;
        y     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done, plus busy-high samples.
    task automatic wait_done(output int lat, output int busy_cnt, output int done_cnt);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        if (!done) begin
            errors++;
            $display("FAIL timeout waiting for done observed=0 expected=1");
        end
    endtask

    int lat, bcnt, dcnt;

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        start  = 1'b0;
        x      = '0;
        y      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        chk("rst_flags", {28'd0, overflow, div_by_zero, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 15 / 3
        launch(32'd15, 32'd3);
        wait_done(lat, bcnt, dcnt);
        chk("15_3_lat", 32'(lat), 32'd33);
        chk("15_3_busy_cycles", 32'(bcnt), 32'd33);
        chk("15_3_result", result, 32'd5);
        chk("15_3_rem", remainder, 32'd0);
        chk("15_3_flags", {30'd0, overflow, div_by_zero}, 32'd0);
        @(posedge clk);
        #1;
        chk("15_3_done_pulse", {31'd0, done}, 32'd0);
        chk("15_3_hold", result, 32'd5);

        // Signed cases
        launch(32'd200, -32'sd20);
        wait_done(lat, bcnt, dcnt);
        chk("200_m20_result", result, -32'sd10);
        chk("200_m20_rem", remainder, 32'd0);

        launch(-32'sd7, 32'd2);
        wait_done(lat, bcnt, dcnt);
        chk("m7_2_result", result, -32'sd3);
        chk("m7_2_rem", remainder, -32'sd1);

        launch(32'd7, -32'sd2);
        wait_done(lat, bcnt, dcnt);
        chk("7_m2_result", result, -32'sd3);
        chk("7_m2_rem", remainder, 32'd1);
        chk("7_m2_flags", {30'd0, overflow, div_by_zero}, 32'd0);

        // Divide by zero
        launch(32'd123, 32'd0);
        wait_done(lat, bcnt, dcnt);
        chk("dbz_lat", 32'(lat), 32'd1);
        chk("dbz_result", result, 32'd0);
        chk("dbz_rem", remainder, 32'd123);
        chk("dbz_flags", {30'd0, overflow, div_by_zero}, 32'd3);

        // Signed overflow
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcnt, dcnt);
        chk("ovf_lat", 32'(lat), 32'd33);
        chk("ovf_result", result, 32'h8000_0000);
        chk("ovf_rem", remainder, 32'd0);
        chk("ovf_flags", {30'd0, overflow, div_by_zero}, 32'd2);

        // start while busy is ignored
        launch(32'd15, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        x     = 32'd8;
        y     = 32'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 5;
        dcnt = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("busy_ign_lat", 32'(lat), 32'd33);
        chk("busy_ign_result", result, 32'd5);
        // Start in the done cycle is accepted
        x     = 32'd8;
        y     = 32'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_done_drop", {30'd0, busy, done}, 32'd2);
        chk("b2b_hold", result, 32'd5);
        wait_done(lat, bcnt, dcnt);
        chk("b2b_lat", 32'(lat), 32'd33);
        chk("b2b_result", result, 32'd4);

        // Asynchronous reset mid-divide
        launch(32'd15, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_result", result, 32'd0);
        chk("arst_flags", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("arst_no_done", 32'(dcnt), 32'd0);
        launch(-32'sd24, 32'd8);
        wait_done(lat, bcnt, dcnt);
        chk("m24_8_result", result, -32'sd3);
        chk("m24_8_rem", remainder, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
